// File: rtl/clk_mux_switch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// clk_mux_switch_ctrl_pkg
//
// Shared definitions for the glitch-free clock mux switch controller:
//   - state_e          : controller FSM states
//   - Def*             : default values for the controller parameters
//   - cnt_width()      : bit width needed to hold a count of 0..max_count
//
// The optional wait-state timeout is enabled with the macro
// CLK_MUX_SWITCH_CTRL_TIMEOUT_EN (see clk_mux_switch_ctrl.sv).
// ---------------------------------------------------------------------------
package clk_mux_switch_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GATE_OFF = 3'd1,
        ST_SWITCH   = 3'd2,
        ST_GATE_ON  = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    localparam int unsigned DefSettleCycles  = 8;
    localparam int unsigned DefTimeoutCycles = 256;
    localparam logic        DefResetSel      = 1'b0;

    // Always returns at least 1 so a zero-width counter is never built.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/clk_mux_switch_ctrl_cnt.sv
// ---------------------------------------------------------------------------
// clk_mux_switch_ctrl_cnt
//
// Loadable saturating down-counter used for both the settle interval and
// the wait-state timeout of the clock mux switch controller.
//
// Ports:
//   clk_i      in   controller clock
//   rst_ni     in   asynchronous active-low reset, clears the count
//   load_i     in   load load_val_i (has priority over en_i)
//   load_val_i in   value loaded when load_i is high
//   en_i       in   decrement by one while the count is non-zero
//   expired_o  out  count has reached zero
// ---------------------------------------------------------------------------
module clk_mux_switch_ctrl_cnt #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             en_i,
    output logic             expired_o
);

    logic [Width-1:0] count_q;

    // Stops at zero so an enable held past expiry cannot wrap around.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - Width'(1);
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/clk_mux_switch_ctrl.sv
// ---------------------------------------------------------------------------
// clk_mux_switch_ctrl
//
// Sequences a glitch-free switch of a clock mux: the downstream clock gate is
// closed, the mux select is changed, a settle interval is waited out and the
// gate is reopened. Runs on an always-on clock independent of the muxed
// clocks. A request whose target equals the current select completes at once.
//
// Parameters:
//   SettleCycles   cycles spent in SWITCH before reopening the gate (1..255)
//   TimeoutCycles  maximum wait for gate status per wait state (2..65535)
//   ResetSel       select value driven out of reset
//
// Ports:
//   clk_i          in   always-on controller clock
//   rst_ni         in   asynchronous active-low reset
//   req_i          in   switch request (level, held until ack_o)
//   req_sel_i      in   target select, sampled when a request is accepted
//   ack_o          out  one-cycle completion pulse
//   busy_o         out  controller not idle
//   sel_o          out  registered select to the clock mux
//   gate_en_o      out  clock gate enable, 1 = clock running
//   gate_status_i  in   gate status synchronised to clk_i, 1 = clock running
//   err_o          out  sticky timeout error
//
// Build option:
//   CLK_MUX_SWITCH_CTRL_TIMEOUT_EN  when defined, GATE_OFF and GATE_ON give
//   up after TimeoutCycles and set err_o. When undefined both wait states
//   wait indefinitely, err_o is tied low and no timeout counter exists.
// ---------------------------------------------------------------------------
module clk_mux_switch_ctrl
    import clk_mux_switch_ctrl_pkg::*;
#(
    parameter int unsigned SettleCycles  = DefSettleCycles,
    parameter int unsigned TimeoutCycles = DefTimeoutCycles,
    parameter logic        ResetSel      = DefResetSel
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_i,
    input  logic req_sel_i,
    output logic ack_o,
    output logic busy_o,
    output logic sel_o,
    output logic gate_en_o,
    input  logic gate_status_i,
    output logic err_o
);

    localparam int unsigned    SettleW    = cnt_width(SettleCycles);
    localparam logic [SettleW-1:0] SettleLoad = SettleW'(SettleCycles - 1);

    if ((SettleCycles < 1) || (SettleCycles > 255)) begin : g_bad_settle
        $error("SettleCycles out of range 1..255");
    end
    if ((TimeoutCycles < 2) || (TimeoutCycles > 65535)) begin : g_bad_timeout
        $error("TimeoutCycles out of range 2..65535");
    end

    state_e state_q, state_d;
    logic   sel_q, sel_d;
    logic   target_q, target_d;
    logic   gate_en_q, gate_en_d;
    logic   ack_q, ack_d;
    logic   state_entry;
    logic   settle_expired;

    // Every state change reloads the counters; only SWITCH loads a
    // non-zero settle count, so other states see the counter cleared.
    assign state_entry = (state_d != state_q);

    clk_mux_switch_ctrl_cnt #(
        .Width (SettleW)
    ) u_settle_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (state_entry),
        .load_val_i ((state_d == ST_SWITCH) ? SettleLoad : '0),
        .en_i       (state_q == ST_SWITCH),
        .expired_o  (settle_expired)
    );

`ifdef CLK_MUX_SWITCH_CTRL_TIMEOUT_EN
    localparam int unsigned     TimeoutW    = cnt_width(TimeoutCycles);
    localparam logic [TimeoutW-1:0] TimeoutLoad = TimeoutW'(TimeoutCycles - 1);

    logic timeout_expired;
    logic err_set;
    logic err_q;
    logic in_wait_q;
    logic in_wait_d;

    assign in_wait_q = (state_q == ST_GATE_OFF) || (state_q == ST_GATE_ON);
    assign in_wait_d = (state_d == ST_GATE_OFF) || (state_d == ST_GATE_ON);

    clk_mux_switch_ctrl_cnt #(
        .Width (TimeoutW)
    ) u_timeout_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (state_entry),
        .load_val_i (in_wait_d ? TimeoutLoad : '0),
        .en_i       (in_wait_q),
        .expired_o  (timeout_expired)
    );

    // Sticky: only reset clears a timeout error.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    // Next-state logic. The status input takes priority over a timeout that
    // expires in the same cycle, so a late-but-valid response still wins.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        sel_d    = sel_q;
`ifdef CLK_MUX_SWITCH_CTRL_TIMEOUT_EN
        err_set  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    if (req_sel_i == sel_q) begin
                        state_d = ST_DONE;
                    end else begin
                        target_d = req_sel_i;
                        state_d  = ST_GATE_OFF;
                    end
                end
            end
            ST_GATE_OFF: begin
                if (!gate_status_i) begin
                    state_d = ST_SWITCH;
                    sel_d   = target_q;
                end
`ifdef CLK_MUX_SWITCH_CTRL_TIMEOUT_EN
                else if (timeout_expired) begin
                    err_set = 1'b1;
                    state_d = ST_GATE_ON;
                end
`endif
            end
            ST_SWITCH: begin
                if (settle_expired) begin
                    state_d = ST_GATE_ON;
                end
            end
            ST_GATE_ON: begin
                if (gate_status_i) begin
                    state_d = ST_DONE;
                end
`ifdef CLK_MUX_SWITCH_CTRL_TIMEOUT_EN
                else if (timeout_expired) begin
                    err_set = 1'b1;
                    state_d = ST_DONE;
                end
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state and registered so the
        // clock gate and mux never see decode glitches.
        gate_en_d = !((state_d == ST_GATE_OFF) || (state_d == ST_SWITCH));
        ack_d     = (state_d == ST_DONE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            sel_q     <= ResetSel;
            target_q  <= ResetSel;
            gate_en_q <= 1'b1;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            target_q  <= target_d;
            gate_en_q <= gate_en_d;
            ack_q     <= ack_d;
        end
    end

    assign sel_o     = sel_q;
    assign gate_en_o = gate_en_q;
    assign ack_o     = ack_q;
    assign busy_o    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_clk_mux_switch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clk_mux_switch_ctrl
//
// Directed bench for clk_mux_switch_ctrl with SettleCycles=8,
// TimeoutCycles=16, ResetSel=0. A one-flop gate model makes gate_status_i
// follow gate_en_o, so the controller reacts to a gate change on the second
// clock edge after it was issued. Timeout scenarios are compiled in when
// CLK_MUX_SWITCH_CTRL_TIMEOUT_EN is defined.
//
// Cycle index i in the capture arrays is the cycle after the i-th rising
// edge following the point where a request was raised (i=0: the cycle right
// after the accepting edge).
// ---------------------------------------------------------------------------
module tb_clk_mux_switch_ctrl;

    logic clk_i = 1'b0;
    logic rst_ni;
    logic req_i = 1'b0;
    logic req_sel_i = 1'b0;
    logic ack_o;
    logic busy_o;
    logic sel_o;
    logic gate_en_o;
    logic gate_status_i;
    logic err_o;

    logic gate_dly = 1'b1;
    logic stuck_en = 1'b0;
    logic stuck_val = 1'b0;

    int checks = 0;
    int errors = 0;

    logic obs_sel  [64];
    logic obs_gate [64];
    logic obs_ack  [64];
    logic obs_busy [64];
    logic obs_err  [64];

    clk_mux_switch_ctrl #(
        .SettleCycles  (8),
        .TimeoutCycles (16),
        .ResetSel      (1'b0)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_i         (req_i),
        .req_sel_i     (req_sel_i),
        .ack_o         (ack_o),
        .busy_o        (busy_o),
        .sel_o         (sel_o),
        .gate_en_o     (gate_en_o),
        .gate_status_i (gate_status_i),
        .err_o         (err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) gate_dly <= gate_en_o;

    assign gate_status_i = stuck_en ? stuck_val : gate_dly;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Records n cycles of outputs. Request is dropped either after cycle
    // drop_at (drop_at >= 0) or on the first ack seen (drop_at < 0).
    task automatic capture(input int n, input int drop_at, input bit flip_sel);
        for (int i = 0; i < n; i++) begin
            tick();
            obs_sel[i]  = sel_o;
            obs_gate[i] = gate_en_o;
            obs_ack[i]  = ack_o;
            obs_busy[i] = busy_o;
            obs_err[i]  = err_o;
            if (i == drop_at) begin
                req_i = 1'b0;
                if (flip_sel) req_sel_i = ~req_sel_i;
            end
            if ((drop_at < 0) && ack_o) req_i = 1'b0;
        end
    endtask

    function automatic int first_idx(input logic a [64], input int from, input int n, input logic v);
        for (int i = from; i < n; i++) begin
            if (a[i] === v) return i;
        end
        return -1;
    endfunction

    function automatic int count_val(input logic a [64], input int from, input int n, input logic v);
        int c = 0;
        for (int i = from; i < n; i++) begin
            if (a[i] === v) c++;
        end
        return c;
    endfunction

    task automatic test_reset();
        rst_ni = 1'b1;
        #1;
        rst_ni = 1'b0;
        #1;
        checks++; if (sel_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_sel: got %0b expected 0", sel_o); end
        checks++; if (gate_en_o !== 1'b1) begin errors++; $display("[TB] FAIL reset_gate_en: got %0b expected 1", gate_en_o); end
        checks++; if (ack_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_ack: got %0b expected 0", ack_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %0b expected 0", err_o); end
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
        tick();
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_busy: got %0b expected 0", busy_o); end
    endtask

    task automatic test_fast_path();
        req_sel_i = 1'b0;
        req_i = 1'b1;
        capture(3, -1, 1'b0);
        checks++; if (obs_ack[0] !== 1'b1) begin errors++; $display("[TB] FAIL fast_ack: got %0b expected 1", obs_ack[0]); end
        checks++; if (obs_busy[0] !== 1'b1) begin errors++; $display("[TB] FAIL fast_busy: got %0b expected 1", obs_busy[0]); end
        checks++; if (obs_busy[1] !== 1'b0) begin errors++; $display("[TB] FAIL fast_busy_end: got %0b expected 0", obs_busy[1]); end
        checks++; if (obs_ack[1] !== 1'b0) begin errors++; $display("[TB] FAIL fast_ack_width: got %0b expected 0", obs_ack[1]); end
        checks++; if (obs_sel[0] !== 1'b0) begin errors++; $display("[TB] FAIL fast_sel: got %0b expected 0", obs_sel[0]); end
        checks++; if (count_val(obs_gate, 0, 3, 1'b0) !== 0) begin errors++; $display("[TB] FAIL fast_gate_low_cycles: got %0d expected 0", count_val(obs_gate, 0, 3, 1'b0)); end
    endtask

    task automatic test_switch();
        req_sel_i = 1'b1;
        req_i = 1'b1;
        capture(20, -1, 1'b0);
        checks++; if (obs_gate[0] !== 1'b0) begin errors++; $display("[TB] FAIL sw_gate_off: got %0b expected 0", obs_gate[0]); end
        checks++; if (first_idx(obs_sel, 0, 20, 1'b1) !== 2) begin errors++; $display("[TB] FAIL sw_sel_rise: got %0d expected 2", first_idx(obs_sel, 0, 20, 1'b1)); end
        checks++; if (obs_gate[2] !== 1'b0) begin errors++; $display("[TB] FAIL sw_gate_at_sel: got %0b expected 0", obs_gate[2]); end
        checks++; if (count_val(obs_gate, 2, 20, 1'b0) !== 8) begin errors++; $display("[TB] FAIL sw_settle_len: got %0d expected 8", count_val(obs_gate, 2, 20, 1'b0)); end
        checks++; if (first_idx(obs_gate, 0, 20, 1'b1) !== 10) begin errors++; $display("[TB] FAIL sw_gate_on: got %0d expected 10", first_idx(obs_gate, 0, 20, 1'b1)); end
        checks++; if (first_idx(obs_ack, 0, 20, 1'b1) !== 12) begin errors++; $display("[TB] FAIL sw_ack_cycle: got %0d expected 12", first_idx(obs_ack, 0, 20, 1'b1)); end
        checks++; if (count_val(obs_ack, 0, 20, 1'b1) !== 1) begin errors++; $display("[TB] FAIL sw_ack_count: got %0d expected 1", count_val(obs_ack, 0, 20, 1'b1)); end
        checks++; if (obs_busy[13] !== 1'b0) begin errors++; $display("[TB] FAIL sw_busy_end: got %0b expected 0", obs_busy[13]); end
        checks++; if (obs_sel[19] !== 1'b1) begin errors++; $display("[TB] FAIL sw_sel_final: got %0b expected 1", obs_sel[19]); end
    endtask

    task automatic test_req_drop();
        req_sel_i = 1'b0;
        req_i = 1'b1;
        capture(20, 0, 1'b1);
        checks++; if (first_idx(obs_sel, 0, 20, 1'b0) !== 2) begin errors++; $display("[TB] FAIL drop_sel_change: got %0d expected 2", first_idx(obs_sel, 0, 20, 1'b0)); end
        checks++; if (first_idx(obs_ack, 0, 20, 1'b1) !== 12) begin errors++; $display("[TB] FAIL drop_ack_cycle: got %0d expected 12", first_idx(obs_ack, 0, 20, 1'b1)); end
        checks++; if (count_val(obs_ack, 0, 20, 1'b1) !== 1) begin errors++; $display("[TB] FAIL drop_ack_count: got %0d expected 1", count_val(obs_ack, 0, 20, 1'b1)); end
        checks++; if (obs_sel[19] !== 1'b0) begin errors++; $display("[TB] FAIL drop_sel_final: got %0b expected 0", obs_sel[19]); end
        req_sel_i = 1'b0;
    endtask

    task automatic test_reset_in_switch();
        req_sel_i = 1'b1;
        req_i = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        checks++; if ((sel_o !== 1'b1) || (gate_en_o !== 1'b0)) begin errors++; $display("[TB] FAIL rsw_in_switch: got sel=%0b gate=%0b expected sel=1 gate=0", sel_o, gate_en_o); end
        req_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        checks++; if (sel_o !== 1'b0) begin errors++; $display("[TB] FAIL rsw_sel: got %0b expected 0", sel_o); end
        checks++; if (gate_en_o !== 1'b1) begin errors++; $display("[TB] FAIL rsw_gate_en: got %0b expected 1", gate_en_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL rsw_busy: got %0b expected 0", busy_o); end
        tick();
        tick();
        rst_ni = 1'b1;
        capture(20, -1, 1'b0);
        checks++; if (count_val(obs_ack, 0, 20, 1'b1) !== 0) begin errors++; $display("[TB] FAIL rsw_no_ack: got %0d expected 0", count_val(obs_ack, 0, 20, 1'b1)); end
        checks++; if (count_val(obs_busy, 0, 20, 1'b1) !== 0) begin errors++; $display("[TB] FAIL rsw_no_resume: got %0d busy cycles expected 0", count_val(obs_busy, 0, 20, 1'b1)); end
        checks++; if (obs_sel[19] !== 1'b0) begin errors++; $display("[TB] FAIL rsw_sel_final: got %0b expected 0", obs_sel[19]); end
    endtask

    task automatic test_back_to_back();
        req_sel_i = 1'b1;
        req_i = 1'b1;
        capture(20, 14, 1'b0);
        checks++; if (first_idx(obs_ack, 0, 20, 1'b1) !== 12) begin errors++; $display("[TB] FAIL b2b_first_ack: got %0d expected 12", first_idx(obs_ack, 0, 20, 1'b1)); end
        checks++; if (obs_busy[13] !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle_gap: got %0b expected 0", obs_busy[13]); end
        checks++; if (first_idx(obs_ack, 13, 20, 1'b1) !== 14) begin errors++; $display("[TB] FAIL b2b_second_ack: got %0d expected 14", first_idx(obs_ack, 13, 20, 1'b1)); end
        checks++; if (count_val(obs_ack, 0, 20, 1'b1) !== 2) begin errors++; $display("[TB] FAIL b2b_ack_count: got %0d expected 2", count_val(obs_ack, 0, 20, 1'b1)); end
        checks++; if ((obs_sel[14] !== 1'b1) || (obs_gate[14] !== 1'b1)) begin errors++; $display("[TB] FAIL b2b_fast_outputs: got sel=%0b gate=%0b expected sel=1 gate=1", obs_sel[14], obs_gate[14]); end
        checks++; if (obs_busy[15] !== 1'b0) begin errors++; $display("[TB] FAIL b2b_busy_end: got %0b expected 0", obs_busy[15]); end
    endtask

`ifdef CLK_MUX_SWITCH_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        // Gate never reports stopped: GATE_OFF gives up after 16 cycles.
        stuck_en = 1'b1;
        stuck_val = 1'b1;
        req_sel_i = 1'b0;
        req_i = 1'b1;
        capture(24, -1, 1'b0);
        checks++; if (obs_err[15] !== 1'b0) begin errors++; $display("[TB] FAIL to_off_err_early: got %0b expected 0", obs_err[15]); end
        checks++; if (first_idx(obs_err, 0, 24, 1'b1) !== 16) begin errors++; $display("[TB] FAIL to_off_err_cycle: got %0d expected 16", first_idx(obs_err, 0, 24, 1'b1)); end
        checks++; if ((obs_sel[16] !== 1'b1) || (obs_gate[16] !== 1'b1)) begin errors++; $display("[TB] FAIL to_off_outputs: got sel=%0b gate=%0b expected sel=1 gate=1", obs_sel[16], obs_gate[16]); end
        checks++; if (first_idx(obs_ack, 0, 24, 1'b1) !== 17) begin errors++; $display("[TB] FAIL to_off_ack_cycle: got %0d expected 17", first_idx(obs_ack, 0, 24, 1'b1)); end
        checks++; if (count_val(obs_ack, 0, 24, 1'b1) !== 1) begin errors++; $display("[TB] FAIL to_off_ack_count: got %0d expected 1", count_val(obs_ack, 0, 24, 1'b1)); end
        // A following successful request leaves the error set.
        req_sel_i = 1'b1;
        req_i = 1'b1;
        capture(6, -1, 1'b0);
        checks++; if (count_val(obs_err, 0, 6, 1'b1) !== 6) begin errors++; $display("[TB] FAIL to_err_sticky: got %0d set cycles expected 6", count_val(obs_err, 0, 6, 1'b1)); end
        checks++; if (count_val(obs_ack, 0, 6, 1'b1) !== 1) begin errors++; $display("[TB] FAIL to_next_ack: got %0d expected 1", count_val(obs_ack, 0, 6, 1'b1)); end
        rst_ni = 1'b0;
        #1;
        checks++; if (err_o !== 1'b0) begin errors++; $display("[TB] FAIL to_err_reset: got %0b expected 0", err_o); end
        tick();
        rst_ni = 1'b1;
        tick();
        // Gate never reports running: GATE_ON gives up after 16 cycles.
        stuck_val = 1'b0;
        req_sel_i = 1'b1;
        req_i = 1'b1;
        capture(30, -1, 1'b0);
        checks++; if (first_idx(obs_sel, 0, 30, 1'b1) !== 1) begin errors++; $display("[TB] FAIL to_on_sel_cycle: got %0d expected 1", first_idx(obs_sel, 0, 30, 1'b1)); end
        checks++; if (first_idx(obs_gate, 0, 30, 1'b1) !== 9) begin errors++; $display("[TB] FAIL to_on_gate_cycle: got %0d expected 9", first_idx(obs_gate, 0, 30, 1'b1)); end
        checks++; if (first_idx(obs_err, 0, 30, 1'b1) !== 25) begin errors++; $display("[TB] FAIL to_on_err_cycle: got %0d expected 25", first_idx(obs_err, 0, 30, 1'b1)); end
        checks++; if (first_idx(obs_ack, 0, 30, 1'b1) !== 25) begin errors++; $display("[TB] FAIL to_on_ack_cycle: got %0d expected 25", first_idx(obs_ack, 0, 30, 1'b1)); end
        stuck_en = 1'b0;
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        tick();
    endtask
`else
    task automatic test_no_timeout();
        // Without the timeout option a stuck gate holds the controller in
        // GATE_OFF indefinitely and err_o never rises.
        stuck_en = 1'b1;
        stuck_val = 1'b1;
        req_sel_i = 1'b0;
        req_i = 1'b1;
        capture(40, -1, 1'b0);
        checks++; if (count_val(obs_ack, 0, 40, 1'b1) !== 0) begin errors++; $display("[TB] FAIL nto_ack: got %0d expected 0", count_val(obs_ack, 0, 40, 1'b1)); end
        checks++; if (count_val(obs_busy, 0, 40, 1'b1) !== 40) begin errors++; $display("[TB] FAIL nto_busy: got %0d expected 40", count_val(obs_busy, 0, 40, 1'b1)); end
        checks++; if (count_val(obs_err, 0, 40, 1'b1) !== 0) begin errors++; $display("[TB] FAIL nto_err: got %0d expected 0", count_val(obs_err, 0, 40, 1'b1)); end
        checks++; if ((obs_gate[39] !== 1'b0) || (obs_sel[39] !== 1'b1)) begin errors++; $display("[TB] FAIL nto_outputs: got gate=%0b sel=%0b expected gate=0 sel=1", obs_gate[39], obs_sel[39]); end
        req_i = 1'b0;
        stuck_en = 1'b0;
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        tick();
        checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL nto_recover: got %0b expected 0", busy_o); end
    endtask
`endif

    initial begin
        $display("[TB] clk_mux_switch_ctrl bench start");
        test_reset();
        test_fast_path();
        test_switch();
        test_req_drop();
        test_reset_in_switch();
        test_back_to_back();
`ifdef CLK_MUX_SWITCH_CTRL_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
